// File: rtl/mips_pkg.sv
// Shared MIPS-R2000 pipeline definitions: control-bit indices, MEM-stage bus state,
// and small decode helpers.
package mips_pkg;

   localparam int unsigned M_BRANCH    = 32'd2;
   localparam int unsigned M_READ      = 32'd1;
   localparam int unsigned M_WRITE     = 32'd0;
   localparam int unsigned WB_REGWRITE = 32'd1;
   localparam int unsigned WB_MEMTOREG = 32'd0;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

   function automatic logic is_mem_op(input logic [2:0] m);
      return m[M_READ] | m[M_WRITE];
   endfunction

   function automatic logic is_misaligned(input logic [31:0] addr);
      return addr[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/mem_bus_fsm.sv
// Data-memory bus sequencer: owns the IDLE/ACCESS state, the timeout counter and the
// dmem_* drive, and reports completion, timeout and read-data strobes to the stage.
module mem_bus_fsm
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT = 32'd16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        start_we,
   input  logic [31:0] start_addr,
   input  logic [31:0] start_wdata,
   input  logic        dmem_ack,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        done,
   output logic        timeout,
   output logic        rd_strobe
);

   localparam int unsigned CW = (TIMEOUT > 32'd2) ? $clog2(TIMEOUT) : 32'd1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 32'd1);

   mem_state_t    state_r;
   logic [CW-1:0] cnt_r;

   assign stall     = (state_r == ACCESS);
   assign done      = (state_r == ACCESS) & dmem_ack;
   // Acknowledge has priority: a timeout is only reported when no ack arrives on that edge.
   assign timeout   = (state_r == ACCESS) & ~dmem_ack & (cnt_r == CNT_MAX);
   assign rd_strobe = done & ~dmem_we;

   // Bus state, timeout counter and registered dmem_* outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         cnt_r      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= 32'h0000_0000;
         dmem_wdata <= 32'h0000_0000;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r    <= ACCESS;
                  cnt_r      <= '0;
                  dmem_req   <= 1'b1;
                  dmem_we    <= start_we;
                  dmem_addr  <= {start_addr[31:2], 2'b00};
                  dmem_wdata <= start_wdata;
               end else begin
                  state_r  <= IDLE;
                  dmem_req <= 1'b0;
               end
            end
            ACCESS: begin
               if (dmem_ack || (cnt_r == CNT_MAX)) begin
                  state_r  <= IDLE;
                  dmem_req <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r  <= IDLE;
               dmem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS-R2000 memory stage: captures the EX bundle, runs loads/stores through
// mem_bus_fsm, and emits a one-cycle-valid MEM/WB bundle.
module mem_stage
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT = 32'd16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [31:0] res,
   input  logic        zero,
   input  logic [31:0] store_data,
   input  logic [4:0]  write_register,
   input  logic [2:0]  m_MEM,
   input  logic [1:0]  wb_MEM,
   output logic        stall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        wb_valid,
   output logic        wb_reg_write,
   output logic        wb_mem_to_reg,
   output logic [31:0] wb_read_data,
   output logic [31:0] wb_alu_res,
   output logic [4:0]  wb_write_register,
   output logic        branch_taken,
   output logic        fault
);

   logic capture_s, mem_op_s, misaligned_s, start_s;
   logic done_s, timeout_s, rd_strobe_s;

   logic [31:0] cap_res_r;
   logic [4:0]  cap_wr_r;
   logic [1:0]  cap_wb_r;
   logic        cap_branch_r;

   assign capture_s    = ~stall & ex_valid;
   assign mem_op_s     = is_mem_op(m_MEM);
   assign misaligned_s = is_misaligned(res);
   assign start_s      = capture_s & mem_op_s & ~misaligned_s;

   mem_bus_fsm #(.TIMEOUT(TIMEOUT)) u_bus (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start_s),
      .start_we    (m_MEM[M_WRITE]),
      .start_addr  (res),
      .start_wdata (store_data),
      .dmem_ack    (dmem_ack),
      .stall       (stall),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .done        (done_s),
      .timeout     (timeout_s),
      .rd_strobe   (rd_strobe_s)
   );

   // EX/MEM capture and MEM/WB output registers; pulses default low every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_res_r         <= 32'h0000_0000;
         cap_wr_r          <= 5'd0;
         cap_wb_r          <= 2'b00;
         cap_branch_r      <= 1'b0;
         wb_valid          <= 1'b0;
         wb_reg_write      <= 1'b0;
         wb_mem_to_reg     <= 1'b0;
         wb_read_data      <= 32'h0000_0000;
         wb_alu_res        <= 32'h0000_0000;
         wb_write_register <= 5'd0;
         branch_taken      <= 1'b0;
         fault             <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         branch_taken <= 1'b0;
         fault        <= 1'b0;
         if (capture_s) begin
            cap_res_r    <= res;
            cap_wr_r     <= write_register;
            cap_wb_r     <= wb_MEM;
            cap_branch_r <= m_MEM[M_BRANCH] & zero;
            if (!start_s) begin
               // Non-memory op or misaligned access completes right away.
               wb_valid          <= 1'b1;
               wb_reg_write      <= wb_MEM[WB_REGWRITE] & ~mem_op_s;
               wb_mem_to_reg     <= wb_MEM[WB_MEMTOREG];
               wb_read_data      <= 32'h0000_0000;
               wb_alu_res        <= res;
               wb_write_register <= write_register;
               branch_taken      <= m_MEM[M_BRANCH] & zero;
               fault             <= mem_op_s;
            end else begin
               wb_valid <= 1'b0;
            end
         end else if (done_s || timeout_s) begin
            wb_valid          <= 1'b1;
            wb_reg_write      <= cap_wb_r[WB_REGWRITE] & done_s;
            wb_mem_to_reg     <= cap_wb_r[WB_MEMTOREG];
            wb_alu_res        <= cap_res_r;
            wb_write_register <= cap_wr_r;
            branch_taken      <= cap_branch_r;
            fault             <= timeout_s;
            if (rd_strobe_s) begin
               wb_read_data <= dmem_rdata;
            end else begin
               wb_read_data <= wb_read_data;
            end
         end else begin
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: one task per scenario, inline comparisons.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid;
   logic [31:0] res;
   logic        zero;
   logic [31:0] store_data;
   logic [4:0]  write_register;
   logic [2:0]  m_MEM;
   logic [1:0]  wb_MEM;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_reg_write;
   logic        wb_mem_to_reg;
   logic [31:0] wb_read_data;
   logic [31:0] wb_alu_res;
   logic [4:0]  wb_write_register;
   logic        branch_taken;
   logic        fault;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage #(.TIMEOUT(32'd16)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ex_valid          (ex_valid),
      .res               (res),
      .zero              (zero),
      .store_data        (store_data),
      .write_register    (write_register),
      .m_MEM             (m_MEM),
      .wb_MEM            (wb_MEM),
      .stall             (stall),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_rdata        (dmem_rdata),
      .dmem_ack          (dmem_ack),
      .wb_valid          (wb_valid),
      .wb_reg_write      (wb_reg_write),
      .wb_mem_to_reg     (wb_mem_to_reg),
      .wb_read_data      (wb_read_data),
      .wb_alu_res        (wb_alu_res),
      .wb_write_register (wb_write_register),
      .branch_taken      (branch_taken),
      .fault             (fault)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic v, input logic [31:0] r, input logic z, input logic [31:0] sd,
                     input logic [4:0] wr, input logic [2:0] m, input logic [1:0] wb);
      ex_valid = v; res = r; zero = z; store_data = sd;
      write_register = wr; m_MEM = m; wb_MEM = wb;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      #1;
      n_checks++;
      if ({stall, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_mem_to_reg, branch_taken, fault} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ctrl: got %b want 00000000",
            {stall, dmem_req, dmem_we, wb_valid, wb_reg_write, wb_mem_to_reg, branch_taken, fault});
      end
      n_checks++;
      if ({dmem_addr, dmem_wdata, wb_read_data, wb_alu_res, wb_write_register} !== 133'd0) begin
         n_fail++; $display("FAIL reset_data: addr=%h wdata=%h rd=%h alu=%h wr=%0d want all 0",
            dmem_addr, dmem_wdata, wb_read_data, wb_alu_res, wb_write_register);
      end
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      ex(1'b1, 32'h5, 1'b0, 32'h0, 5'd3, 3'b000, 2'b10);
      step();
      n_checks++;
      if ({wb_valid, stall, wb_reg_write} !== 3'b101 || wb_alu_res !== 32'h5 || wb_write_register !== 5'd3) begin
         n_fail++; $display("FAIL b2b_first: valid/stall/rw=%b alu=%h wr=%0d want 101 5 3",
            {wb_valid, stall, wb_reg_write}, wb_alu_res, wb_write_register);
      end
      ex(1'b1, 32'h6, 1'b0, 32'h0, 5'd4, 3'b000, 2'b10);
      step();
      n_checks++;
      if ({wb_valid, stall} !== 2'b10 || wb_alu_res !== 32'h6 || wb_write_register !== 5'd4 || wb_read_data !== 32'h0) begin
         n_fail++; $display("FAIL b2b_second: valid/stall=%b alu=%h wr=%0d rd=%h want 10 6 4 0",
            {wb_valid, stall}, wb_alu_res, wb_write_register, wb_read_data);
      end
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      step();
      n_checks++;
      if (wb_valid !== 1'b0 || wb_alu_res !== 32'h6) begin
         n_fail++; $display("FAIL b2b_idle: valid=%b alu=%h want 0 6", wb_valid, wb_alu_res);
      end
   endtask

   task automatic test_load();
      int stall_cycles = 0;
      ex(1'b1, 32'h100, 1'b0, 32'h0, 5'd8, 3'b010, 2'b11);
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      n_checks++;
      if ({dmem_req, dmem_we, stall, wb_valid} !== 4'b1010 || dmem_addr !== 32'h100) begin
         n_fail++; $display("FAIL lw_req: req/we/stall/valid=%b addr=%h want 1010 100",
            {dmem_req, dmem_we, stall, wb_valid}, dmem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         if (stall) stall_cycles++;
         if (i == 2) begin
            dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
         end
         step();
      end
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      n_checks++;
      if (stall_cycles != 3) begin
         n_fail++; $display("FAIL lw_stall_len: got %0d want 3", stall_cycles);
      end
      n_checks++;
      if ({wb_valid, stall, dmem_req, wb_mem_to_reg, wb_reg_write, fault} !== 6'b100110 ||
          wb_read_data !== 32'hDEAD_BEEF || wb_write_register !== 5'd8) begin
         n_fail++; $display("FAIL lw_done: v/st/req/m2r/rw/f=%b rd=%h wr=%0d want 100110 deadbeef 8",
            {wb_valid, stall, dmem_req, wb_mem_to_reg, wb_reg_write, fault}, wb_read_data, wb_write_register);
      end
      step();
      n_checks++;
      if (wb_valid !== 1'b0 || wb_read_data !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL lw_hold: valid=%b rd=%h want 0 deadbeef", wb_valid, wb_read_data);
      end
   endtask

   task automatic test_misaligned();
      ex(1'b1, 32'h102, 1'b0, 32'h55, 5'd0, 3'b001, 2'b00);
      step();
      n_checks++;
      if ({dmem_req, stall, wb_valid, fault, wb_reg_write} !== 5'b00110) begin
         n_fail++; $display("FAIL sw_misaligned: req/st/v/f/rw=%b want 00110",
            {dmem_req, stall, wb_valid, fault, wb_reg_write});
      end
      ex(1'b1, 32'h101, 1'b0, 32'h0, 5'd7, 3'b010, 2'b11);
      step();
      n_checks++;
      if ({dmem_req, wb_valid, fault, wb_reg_write} !== 4'b0110) begin
         n_fail++; $display("FAIL lw_misaligned: req/v/f/rw=%b want 0110",
            {dmem_req, wb_valid, fault, wb_reg_write});
      end
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      step();
      n_checks++;
      if ({wb_valid, fault, dmem_req} !== 3'b000) begin
         n_fail++; $display("FAIL misaligned_pulse: v/f/req=%b want 000", {wb_valid, fault, dmem_req});
      end
   endtask

   task automatic test_timeout();
      int req_cycles = 0;
      logic stable = 1'b1;
      ex(1'b1, 32'h40, 1'b0, 32'h1234, 5'd0, 3'b001, 2'b00);
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      while (dmem_req && req_cycles < 40) begin
         req_cycles++;
         if (dmem_we !== 1'b1 || dmem_addr !== 32'h40 || dmem_wdata !== 32'h1234 || fault !== 1'b0) stable = 1'b0;
         step();
      end
      n_checks++;
      if (req_cycles != 16) begin
         n_fail++; $display("FAIL sw_timeout_len: got %0d want 16", req_cycles);
      end
      n_checks++;
      if (stable !== 1'b1) begin
         n_fail++; $display("FAIL sw_bus_stable: got %b want 1", stable);
      end
      n_checks++;
      if ({fault, wb_valid, wb_reg_write, stall} !== 4'b1100) begin
         n_fail++; $display("FAIL sw_timeout_fault: f/v/rw/st=%b want 1100",
            {fault, wb_valid, wb_reg_write, stall});
      end
      step();
      n_checks++;
      if ({fault, wb_valid} !== 2'b00) begin
         n_fail++; $display("FAIL timeout_pulse: f/v=%b want 00", {fault, wb_valid});
      end
   endtask

   task automatic test_ack_at_timeout();
      ex(1'b1, 32'h80, 1'b0, 32'h0, 5'd2, 3'b010, 2'b11);
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      for (int i = 0; i < 15; i++) step();
      n_checks++;
      if (dmem_req !== 1'b1) begin
         n_fail++; $display("FAIL ack_edge_req: got %b want 1", dmem_req);
      end
      dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      step();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      n_checks++;
      if ({wb_valid, fault, wb_reg_write, dmem_req} !== 4'b1010 || wb_read_data !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL ack_beats_timeout: v/f/rw/req=%b rd=%h want 1010 cafef00d",
            {wb_valid, fault, wb_reg_write, dmem_req}, wb_read_data);
      end
   endtask

   task automatic test_branch();
      ex(1'b1, 32'h0, 1'b1, 32'h0, 5'd0, 3'b100, 2'b00);
      step();
      n_checks++;
      if ({branch_taken, wb_valid} !== 2'b11) begin
         n_fail++; $display("FAIL beq_taken: bt/v=%b want 11", {branch_taken, wb_valid});
      end
      ex(1'b1, 32'h1, 1'b0, 32'h0, 5'd0, 3'b100, 2'b00);
      step();
      n_checks++;
      if ({branch_taken, wb_valid} !== 2'b01) begin
         n_fail++; $display("FAIL beq_not_taken: bt/v=%b want 01", {branch_taken, wb_valid});
      end
      ex(1'b0, 32'h0, 1'b1, 32'h0, 5'd0, 3'b100, 2'b00);
      step();
      n_checks++;
      if ({branch_taken, wb_valid} !== 2'b00) begin
         n_fail++; $display("FAIL beq_idle: bt/v=%b want 00", {branch_taken, wb_valid});
      end
   endtask

   task automatic test_held_bundle();
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      n_checks++;
      if ({wb_valid, stall, dmem_req} !== 3'b000) begin
         n_fail++; $display("FAIL idle_ack_ignored: v/st/req=%b want 000", {wb_valid, stall, dmem_req});
      end
      ex(1'b1, 32'h200, 1'b0, 32'h0, 5'd6, 3'b010, 2'b11);
      step();
      ex(1'b1, 32'h77, 1'b0, 32'h0, 5'd9, 3'b000, 2'b10);
      dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_F00D;
      step();
      dmem_ack = 1'b0; dmem_rdata = 32'h0;
      n_checks++;
      if ({wb_valid, stall} !== 2'b10 || wb_alu_res !== 32'h200 || wb_write_register !== 5'd6 ||
          wb_read_data !== 32'h0BAD_F00D) begin
         n_fail++; $display("FAIL held_load: v/st=%b alu=%h wr=%0d rd=%h want 10 200 6 0badf00d",
            {wb_valid, stall}, wb_alu_res, wb_write_register, wb_read_data);
      end
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      n_checks++;
      if (wb_valid !== 1'b1 || wb_alu_res !== 32'h77 || wb_write_register !== 5'd9 || wb_read_data !== 32'h0) begin
         n_fail++; $display("FAIL held_add: v=%b alu=%h wr=%0d rd=%h want 1 77 9 0",
            wb_valid, wb_alu_res, wb_write_register, wb_read_data);
      end
      step();
   endtask

   task automatic test_reset_mid_access();
      ex(1'b1, 32'h300, 1'b0, 32'h0, 5'd1, 3'b010, 2'b11);
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      step();
      n_checks++;
      if ({dmem_req, stall} !== 2'b11) begin
         n_fail++; $display("FAIL mid_access_pre: req/st=%b want 11", {dmem_req, stall});
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({dmem_req, stall, wb_valid} !== 3'b000) begin
         n_fail++; $display("FAIL mid_access_async: req/st/v=%b want 000", {dmem_req, stall, wb_valid});
      end
      #2 rst_n = 1'b1;
      dmem_ack = 1'b1; dmem_rdata = 32'h5151_5151;
      step();
      dmem_ack = 1'b0;
      n_checks++;
      if ({wb_valid, stall, dmem_req} !== 3'b000) begin
         n_fail++; $display("FAIL post_reset_quiet: v/st/req=%b want 000", {wb_valid, stall, dmem_req});
      end
      ex(1'b1, 32'h11, 1'b0, 32'h0, 5'd5, 3'b000, 2'b10);
      step();
      ex(1'b0, 32'h0, 1'b0, 32'h0, 5'd0, 3'b000, 2'b00);
      n_checks++;
      if ({wb_valid, wb_reg_write, wb_mem_to_reg} !== 3'b110 || wb_alu_res !== 32'h11 ||
          wb_write_register !== 5'd5 || wb_read_data !== 32'h0) begin
         n_fail++; $display("FAIL post_reset_add: v/rw/m2r=%b alu=%h wr=%0d rd=%h want 110 11 5 0",
            {wb_valid, wb_reg_write, wb_mem_to_reg}, wb_alu_res, wb_write_register, wb_read_data);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_load();
      test_misaligned();
      test_timeout();
      test_ack_at_timeout();
      test_branch();
      test_held_bundle();
      test_reset_mid_access();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
